// File: rtl/serial_add_sub_pkg.sv
// rtl/serial_add_sub_pkg.sv - shared constants and helpers for the bit-serial add/sub unit
package serial_add_sub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Bit counter never needs fewer than one bit, even for a 1-bit datapath.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// rtl/serial_add_sub_if.sv - request/result bundle for serial_add_sub
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, mode, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, mode, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_sub_fa_cell.sv
// rtl/serial_add_sub_fa_cell.sv - combinational one-bit full adder
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial adder/subtractor, LSB first, one bit per clock
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_add_sub_if.slave bus
);
    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_next;
    logic             c_r;
    logic             cout_r;
    logic             ovf_r;
    logic             fa_s;
    logic             fa_co;

    fa_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (c_r),
        .s  (fa_s),
        .co (fa_co)
    );

    // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    always_comb begin
        sum_next            = sum_r >> 1;
        sum_next[WIDTH-1]   = fa_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            c_r    <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        // Subtract is a + ~b + 1: invert B and preload the carry.
                        b_sh  <= (bus.mode == MODE_SUB) ? ~bus.b : bus.b;
                        c_r   <= (bus.mode == MODE_SUB) ? 1'b1 : bus.cin;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    sum_r <= sum_next;
                    c_r   <= fa_co;
                    if (cnt == LAST) begin
                        cout_r <= fa_co;
                        ovf_r  <= c_r ^ fa_co;
                        state  <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = (state != ST_IDLE);
    assign bus.done = (state == ST_DONE);
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - self-checking bench for serial_add_sub at WIDTH 8, 1 and 32
module tb_serial_add_sub;
    import serial_add_sub_pkg::*;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_add_sub_if #(.WIDTH(8))  if8 ();
    serial_add_sub_if #(.WIDTH(1))  if1 ();
    serial_add_sub_if #(.WIDTH(32)) if32 ();

    serial_add_sub #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
    serial_add_sub #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
    serial_add_sub #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [63:0] wmask(input int w);
        return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic exp_t model(input int w, input logic m, input logic [63:0] av,
                                   input logic [63:0] bv, input logic c);
        logic [64:0] full;
        logic [63:0] am, be;
        exp_t        e;
        am     = av & wmask(w);
        be     = ((m == MODE_SUB) ? ~bv : bv) & wmask(w);
        full   = {1'b0, am} + {1'b0, be} + ((m == MODE_SUB) ? 65'd1 : {64'd0, c});
        e.sum  = full[63:0] & wmask(w);
        e.cout = full[w];
        e.ovf  = (am[w-1] == be[w-1]) && (e.sum[w-1] != am[w-1]);
        return e;
    endfunction

    task automatic drive(input int which, input logic s, input logic m,
                         input logic [63:0] av, input logic [63:0] bv, input logic c);
        case (which)
            0: begin if8.start = s;  if8.mode = m;  if8.a = av[7:0];  if8.b = bv[7:0];  if8.cin = c;  end
            1: begin if1.start = s;  if1.mode = m;  if1.a = av[0:0];  if1.b = bv[0:0];  if1.cin = c;  end
            default: begin if32.start = s; if32.mode = m; if32.a = av[31:0]; if32.b = bv[31:0]; if32.cin = c; end
        endcase
    endtask

    task automatic sample(input int which, output logic d, output logic bz,
                          output logic [63:0] s, output logic co, output logic ov);
        case (which)
            0: begin d = if8.done;  bz = if8.busy;  s = {56'd0, if8.sum};  co = if8.cout;  ov = if8.ovf;  end
            1: begin d = if1.done;  bz = if1.busy;  s = {63'd0, if1.sum};  co = if1.cout;  ov = if1.ovf;  end
            default: begin d = if32.done; bz = if32.busy; s = {32'd0, if32.sum}; co = if32.cout; ov = if32.ovf; end
        endcase
    endtask

    // Issue one op, scramble inputs right after the start edge, wait for done.
    // lat counts clock edges from the start edge (inclusive) to the edge that raised done.
    task automatic run_op(input int which, input logic m, input logic [63:0] av,
                          input logic [63:0] bv, input logic c, output int lat, output int busy_n,
                          output logic [63:0] s, output logic co, output logic ov, output logic ok);
        logic d, bz;
        @(negedge clk);
        drive(which, 1'b1, m, av, bv, c);
        lat = 0; busy_n = 0; ok = 1'b0;
        s = '0; co = 1'b0; ov = 1'b0;
        while (!ok && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) drive(which, 1'b0, ~m, {$urandom, $urandom}, {$urandom, $urandom}, ~c);
            sample(which, d, bz, s, co, ov);
            if (bz) busy_n++;
            if (d) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic d, bz, co, ov;
        logic [63:0] s;
        drive(0, 1'b0, MODE_ADD, 64'd0, 64'd0, 1'b0);
        drive(1, 1'b0, MODE_ADD, 64'd0, 64'd0, 1'b0);
        drive(2, 1'b0, MODE_ADD, 64'd0, 64'd0, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int w = 0; w < 3; w++) begin
            sample(w, d, bz, s, co, ov);
            checks++;
            if ({d, bz, s, co, ov} !== 68'd0) begin
                errors++;
                $display("FAIL reset_state dut%0d: done=%b busy=%b sum=%h cout=%b ovf=%b, required all 0", w, d, bz, s, co, ov);
            end
        end
    endtask

    task automatic test_add_sub;
        logic        m_t [4] = '{MODE_ADD, MODE_ADD, MODE_SUB, MODE_SUB};
        logic [7:0]  a_t [4] = '{8'h3C, 8'hFF, 8'h10, 8'h80};
        logic [7:0]  b_t [4] = '{8'h5A, 8'h01, 8'h20, 8'h01};
        logic        c_t [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0]  s_t [4] = '{8'h96, 8'h01, 8'hF0, 8'h7F};
        logic        co_t[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic        ov_t[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int lat, busy_n;
        logic [63:0] s;
        logic co, ov, ok;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            sbq.push_back('{sum: {56'd0, s_t[i]}, cout: co_t[i], ovf: ov_t[i]});
            run_op(0, m_t[i], {56'd0, a_t[i]}, {56'd0, b_t[i]}, c_t[i], lat, busy_n, s, co, ov, ok);
            e = sbq.pop_front();
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL vec%0d_timeout: no done within %0d cycles, required done", i, lat);
            end else if ({s, co, ov} !== {e.sum, e.cout, e.ovf}) begin
                errors++;
                $display("FAIL vec%0d_result: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                         i, s, co, ov, e.sum, e.cout, e.ovf);
            end
            checks++;
            if (lat !== 9 || busy_n !== 9) begin
                errors++;
                $display("FAIL vec%0d_timing: latency=%0d busy_cycles=%0d, required 9 and 9", i, lat, busy_n);
            end
        end
    endtask

    task automatic test_start_while_busy;
        logic d, bz, co, ov;
        logic [63:0] s;
        int ndone = 0, done_lat = 0;
        exp_t e;
        sbq.push_back(model(8, MODE_ADD, 64'h01, 64'h01, 1'b0));
        @(negedge clk);
        drive(0, 1'b1, MODE_ADD, 64'h01, 64'h01, 1'b0);
        for (int lat = 1; lat <= 30; lat++) begin
            @(posedge clk);
            @(negedge clk);
            if (lat == 1) drive(0, 1'b0, MODE_ADD, 64'h01, 64'h01, 1'b0);
            if (lat == 3) drive(0, 1'b1, MODE_ADD, 64'hFF, 64'h01, 1'b0);
            if (lat == 4) drive(0, 1'b0, MODE_SUB, 64'h77, 64'h33, 1'b1);
            sample(0, d, bz, s, co, ov);
            if (d) begin
                ndone++;
                if (ndone == 1) begin
                    done_lat = lat;
                    e = sbq.pop_front();
                    checks++;
                    if (s !== e.sum || s !== 64'h02) begin
                        errors++;
                        $display("FAIL busy_start_sum: sum=%h, required %h", s, e.sum);
                    end
                end
            end
        end
        checks++;
        if (ndone !== 1 || done_lat !== 9) begin
            errors++;
            $display("FAIL busy_start_dones: count=%0d at latency %0d, required 1 at 9", ndone, done_lat);
        end
    endtask

    task automatic test_reset_mid_run;
        logic d, bz, co, ov, ok;
        logic [63:0] s;
        int lat, busy_n, late_done = 0;
        exp_t e;
        @(negedge clk);
        drive(0, 1'b1, MODE_ADD, 64'hFF, 64'hFF, 1'b1);
        for (int l = 1; l <= 4; l++) begin
            @(posedge clk);
            @(negedge clk);
            if (l == 1) drive(0, 1'b0, MODE_ADD, 64'h00, 64'h00, 1'b0);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sample(0, d, bz, s, co, ov);
        checks++;
        if ({d, bz, s, co, ov} !== 68'd0) begin
            errors++;
            $display("FAIL mid_reset_state: done=%b busy=%b sum=%h cout=%b ovf=%b, required all 0", d, bz, s, co, ov);
        end
        repeat (12) begin
            @(negedge clk);
            sample(0, d, bz, s, co, ov);
            if (d || bz) late_done++;
        end
        checks++;
        if (late_done !== 0) begin
            errors++;
            $display("FAIL mid_reset_discard: %0d active cycles after reset, required 0", late_done);
        end
        sbq.push_back(model(8, MODE_ADD, 64'h05, 64'h03, 1'b0));
        run_op(0, MODE_ADD, 64'h05, 64'h03, 1'b0, lat, busy_n, s, co, ov, ok);
        e = sbq.pop_front();
        checks++;
        if (!ok || s !== 64'h08 || s !== e.sum || lat !== 9) begin
            errors++;
            $display("FAIL post_reset_op: ok=%b sum=%h latency=%0d, required ok=1 sum=%h latency 9", ok, s, lat, e.sum);
        end
    endtask

    task automatic test_random(input int which, input int w, input int n);
        logic m, c, co, ov, ok;
        logic [63:0] av, bv, s;
        int lat, busy_n, bad = 0;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            m  = 1'($urandom_range(0, 1));
            c  = 1'($urandom_range(0, 1));
            av = {$urandom, $urandom} & wmask(w);
            bv = {$urandom, $urandom} & wmask(w);
            sbq.push_back(model(w, m, av, bv, c));
            run_op(which, m, av, bv, c, lat, busy_n, s, co, ov, ok);
            e = sbq.pop_front();
            checks++;
            if (!ok || {s, co, ov} !== {e.sum, e.cout, e.ovf}) begin
                errors++;
                if (bad++ < 8)
                    $display("FAIL rand_w%0d_result op%0d m=%b a=%h b=%h cin=%b: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                             w, i, m, av, bv, c, s, co, ov, e.sum, e.cout, e.ovf);
            end
            checks++;
            if (lat !== w + 1) begin
                errors++;
                if (bad++ < 8)
                    $display("FAIL rand_w%0d_latency op%0d: %0d, required %0d", w, i, lat, w + 1);
            end
            if (!ok) break;
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_start_while_busy();
        test_reset_mid_run();
        test_random(1, 1, 1000);
        test_random(2, 32, 1000);
        test_random(0, 8, 200);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
